// File: rtl/window3x3_gen.sv
// 3x3 sliding-window generator: two line buffers plus a register window over a raster pixel stream.
// Optional WIN3_FRAME_DONE_EN adds out_frame_done, pulsed with the last window of each frame.
module window3x3_gen #(
  parameter int COLS   = 640,
  parameter int ROWS   = 480,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  output logic [9*DATA_W-1:0]   out_win
`ifdef WIN3_FRAME_DONE_EN
  ,
  output logic                  out_frame_done
`endif
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // lb_up1 holds row r-1, lb_up2 holds row r-2, both indexed by column.
  logic [DATA_W-1:0] lb_up1 [COLS];
  logic [DATA_W-1:0] lb_up2 [COLS];

  logic [DATA_W-1:0] up1_rd, up2_rd;
  logic [DATA_W-1:0] top_l, top_m, mid_l, mid_m, bot_l, bot_m;
  logic [9*DATA_W-1:0] win_next;
  logic last_col, last_row, win_ok;

  assign up1_rd   = lb_up1[col];
  assign up2_rd   = lb_up2[col];
  assign last_col = (col == CW'(COLS - 1));
  assign last_row = (row == RW'(ROWS - 1));
  assign win_ok   = in_valid && (row >= RW'(2)) && (col >= CW'(2));

  // Right column comes straight from the buffers and the incoming pixel.
  assign win_next = {top_l, top_m, up2_rd,
                     mid_l, mid_m, up1_rd,
                     bot_l, bot_m, in_data};

  // NOTE: line buffers are plain RAM with no reset; stale contents are never
  // flagged because out_valid also requires row >= 2 after every reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_up1[col] <= in_data;
      lb_up2[col] <= up1_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      top_l     <= '0;
      top_m     <= '0;
      mid_l     <= '0;
      mid_m     <= '0;
      bot_l     <= '0;
      bot_m     <= '0;
      out_valid <= 1'b0;
      out_win   <= '0;
    end else begin
      out_valid <= win_ok;
      if (win_ok) out_win <= win_next;
      if (in_valid) begin
        // Left/middle columns shift; windows with col < 2 are never flagged,
        // so leftovers from the previous row cannot leak into a valid window.
        top_l <= top_m;
        top_m <= up2_rd;
        mid_l <= mid_m;
        mid_m <= up1_rd;
        bot_l <= bot_m;
        bot_m <= in_data;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

`ifdef WIN3_FRAME_DONE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_frame_done <= 1'b0;
    else        out_frame_done <= in_valid && last_col && last_row;
  end
`endif

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench for window3x3_gen: driver pushes windows computed from an image model,
// a monitor pops and compares whenever out_valid is seen.
module tb_window3x3_gen;

  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int DW   = 8;
  localparam int WW   = 9 * DW;
  localparam logic [WW-1:0] FIRST_F1 = 72'h000102_08090a_101112;
  localparam logic [WW-1:0] FIRST_F2 = 72'h646566_6c6d6e_747576;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [WW-1:0] out_win;
`ifdef WIN3_FRAME_DONE_EN
  logic          out_frame_done;
`endif

  window3x3_gen #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_win  (out_win)
`ifdef WIN3_FRAME_DONE_EN
    ,
    .out_frame_done(out_frame_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] win;
    logic          fd;
  } exp_t;

  exp_t          q[$];
  logic [WW-1:0] seen[$];
  logic [DW-1:0] img[ROWS][COLS];
  logic [WW-1:0] last_exp = '0;
  int checks = 0, errors = 0, n_valid = 0, n_fd = 0;
  int mr = 0, mc = 0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the window is simply the 3x3 image block ending at the pixel just sent.
  task automatic send(input logic [DW-1:0] v);
    exp_t e;
    logic [WW-1:0] w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    img[mr][mc] = v;
    if (mr >= 2 && mc >= 2) begin
      w = '0;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          w = {w[WW-DW-1:0], img[mr-2+dr][mc-2+dc]};
      e.win = w;
      e.fd  = (mr == ROWS - 1) && (mc == COLS - 1);
      q.push_back(e);
    end
    if (mc == COLS - 1) begin
      mc = 0;
      mr = (mr == ROWS - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = DW'($urandom);
    end
  endtask

  // mode 0: continuous, 1: gap after every pixel, 2: random data and random gaps
  task automatic frame(input int mode, input int offset);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        send(mode == 2 ? DW'($urandom) : DW'(r * COLS + c + offset));
        if (mode == 1) idle(1);
        if (mode == 2) idle(int'($urandom_range(0, 3)));
      end
  endtask

  // Monitor: latency-1 contract means any pending entry must appear at this edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      check("reset_valid", WW'(out_valid), '0);
      check("reset_win", out_win, '0);
`ifdef WIN3_FRAME_DONE_EN
      check("reset_frame_done", WW'(out_frame_done), '0);
`endif
      last_exp = '0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", WW'(out_valid), '0);
      end else begin
        e = q.pop_front();
        check("window", out_win, e.win);
`ifdef WIN3_FRAME_DONE_EN
        check("frame_done", WW'(out_frame_done), WW'(e.fd));
        if (out_frame_done) n_fd++;
`endif
        last_exp = e.win;
        seen.push_back(out_win);
        n_valid++;
      end
    end else begin
      if (q.size() != 0) begin
        check("missing_valid", WW'(out_valid), WW'(1));
        void'(q.pop_front());
      end
      check("hold_win", out_win, last_exp);
`ifdef WIN3_FRAME_DONE_EN
      check("frame_done_idle", WW'(out_frame_done), '0);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_fd;
    idle(3);
    @(negedge clk) rst_n = 1'b1;

    // Continuous single frame
    base = n_valid; base_fd = n_fd; seen.delete();
    frame(0, 0);
    idle(3);
    check("f1_count", WW'(n_valid - base), WW'(24));
    check("f1_first", seen.size() > 0 ? seen[0] : '0, FIRST_F1);
`ifdef WIN3_FRAME_DONE_EN
    check("f1_fd_count", WW'(n_fd - base_fd), WW'(1));
`endif

    // Same frame with a gap after every pixel
    base = n_valid; seen.delete();
    frame(1, 0);
    idle(3);
    check("gap_count", WW'(n_valid - base), WW'(24));
    check("gap_first", seen.size() > 0 ? seen[0] : '0, FIRST_F1);

    // Back-to-back frames, second offset by 100
    base = n_valid; seen.delete();
    frame(0, 0);
    frame(0, 100);
    idle(3);
    check("b2b_count", WW'(n_valid - base), WW'(48));
    check("b2b_first_f2", seen.size() > 24 ? seen[24] : '0, FIRST_F2);

    // Reset after 20 pixels, released so the next edge accepts pixel (0,0)
    for (int i = 0; i < 20; i++) send(DW'(i));
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    mr = 0; mc = 0;
    q.delete();
    idle(3);
    @(posedge clk);
    #2 rst_n = 1'b1;
    base = n_valid; base_fd = n_fd; seen.delete();
    frame(0, 0);
    idle(3);
    check("rst_count", WW'(n_valid - base), WW'(24));
    check("rst_first", seen.size() > 0 ? seen[0] : '0, FIRST_F1);
`ifdef WIN3_FRAME_DONE_EN
    check("rst_fd_count", WW'(n_fd - base_fd), WW'(1));
`endif

    // Random data with random gaps, two frames
    base = n_valid;
    frame(2, 0);
    frame(2, 0);
    idle(4);
    check("rand_count", WW'(n_valid - base), WW'(48));
    check("queue_empty", WW'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
